// File: rtl/pc_unit.sv
// pc_unit: registered next-fetch-address generator for the IF stage.
// Chooses the next PC from reset, run enable, exception, branch, stall,
// call/return prediction (circular return-address stack) and sequential
// fetch, in that priority order. Every output comes straight from a flop.
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(8'h80),
  parameter int unsigned       STEP      = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_ovf_o,
  output logic             ret_err_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};

  // Architectural state
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] epc_r;
  logic [WIDTH-1:0] ras_r [RAS_DEPTH];
  logic [PW-1:0]    top_r;      // index of the most recent entry
  logic [CW-1:0]    cnt_r;      // valid entries, 0..RAS_DEPTH
  logic             ovf_r;
  logic             ret_err_r;
  logic             empty_r;
  logic             full_r;

  // Next-state values
  logic [WIDTH-1:0] seq_s;
  logic [WIDTH-1:0] pc_n_s;
  logic [WIDTH-1:0] epc_n_s;
  logic [PW-1:0]    top_n_s;
  logic [CW-1:0]    cnt_n_s;
  logic             ovf_n_s;
  logic             ret_err_n_s;
  logic             ras_we_s;
  logic [PW-1:0]    ras_widx_s;
  logic [PW-1:0]    top_inc_s;
  logic [PW-1:0]    top_dec_s;
  logic             ras_nonempty_s;
  logic             ras_isfull_s;

  // Prioritised next-PC / RAS update for one edge (reset handled in the flop block)
  always_comb begin
    seq_s          = pc_r + WIDTH'(STEP);
    top_inc_s      = top_r + PW'(1);
    top_dec_s      = top_r - PW'(1);
    ras_nonempty_s = (cnt_r != CNT_ZERO_C);
    ras_isfull_s   = (cnt_r == DEPTH_C);

    pc_n_s      = pc_r;
    epc_n_s     = epc_r;
    top_n_s     = top_r;
    cnt_n_s     = cnt_r;
    ovf_n_s     = ovf_r;
    ret_err_n_s = 1'b0;
    ras_we_s    = 1'b0;
    ras_widx_s  = top_r;

    if (!start_i) begin
      // frozen: everything holds, error pulse drops
      pc_n_s = pc_r;
    end else if (exc_i) begin
      pc_n_s  = EXC_VEC;
      epc_n_s = pc_r;
    end else if (br_taken_i) begin
      pc_n_s = br_target_i;
    end else if (stall_i) begin
      pc_n_s = pc_r;
    end else if (ret_i && ras_nonempty_s) begin
      // return predicted from the top entry; a simultaneous call swaps it
      pc_n_s = ras_r[top_r];
      if (call_i) begin
        ras_we_s   = 1'b1;
        ras_widx_s = top_r;
      end else begin
        top_n_s = top_dec_s;
        cnt_n_s = cnt_r - CW'(1);
      end
    end else if (call_i) begin
      // push; when full the slot after top is the oldest entry
      pc_n_s      = jmp_target_i;
      ras_we_s    = 1'b1;
      ras_widx_s  = top_inc_s;
      top_n_s     = top_inc_s;
      ret_err_n_s = ret_i;
      if (ras_isfull_s) begin
        ovf_n_s = 1'b1;
      end else begin
        cnt_n_s = cnt_r + CW'(1);
      end
    end else if (ret_i) begin
      // return with nothing to predict from
      pc_n_s      = seq_s;
      ret_err_n_s = 1'b1;
    end else begin
      pc_n_s = seq_s;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_r      <= RESET_VEC;
      epc_r     <= {WIDTH{1'b0}};
      top_r     <= {PW{1'b1}};
      cnt_r     <= CNT_ZERO_C;
      ovf_r     <= 1'b0;
      ret_err_r <= 1'b0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pc_r      <= pc_n_s;
      epc_r     <= epc_n_s;
      top_r     <= top_n_s;
      cnt_r     <= cnt_n_s;
      ovf_r     <= ovf_n_s;
      ret_err_r <= ret_err_n_s;
      empty_r   <= (cnt_n_s == CNT_ZERO_C);
      full_r    <= (cnt_n_s == DEPTH_C);
      if (ras_we_s) begin
        ras_r[ras_widx_s] <= seq_s;
      end
    end
  end

  assign pc_o        = pc_r;
  assign epc_o       = epc_r;
  assign ras_empty_o = empty_r;
  assign ras_full_o  = full_r;
  assign ras_ovf_o   = ovf_r;
  assign ret_err_o   = ret_err_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a queue-based reference model is compared
// against the 32-bit instance every cycle, plus literal pins on both the
// 32-bit instance and an 8-bit instance used for the address wrap.
module tb_pc_unit;

  logic        clk;
  logic        rst, start, stall, exc, br, call, ret;
  logic [31:0] br_tgt, jmp_tgt;
  logic [31:0] pc, epc;
  logic        empty, full, ovf, rerr;

  logic        b_br;
  logic [7:0]  b_tgt;
  logic [7:0]  b_pc, b_epc;
  logic        b_empty, b_full, b_ovf, b_rerr;

  int n_checks = 0;
  int n_err    = 0;

  pc_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .exc_i(exc),
    .br_taken_i(br), .br_target_i(br_tgt), .call_i(call), .jmp_target_i(jmp_tgt),
    .ret_i(ret), .pc_o(pc), .epc_o(epc), .ras_empty_o(empty), .ras_full_o(full),
    .ras_ovf_o(ovf), .ret_err_o(rerr)
  );

  pc_unit #(.WIDTH(8), .STEP(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(1'b0), .exc_i(1'b0),
    .br_taken_i(b_br), .br_target_i(b_tgt), .call_i(1'b0), .jmp_target_i(8'h00),
    .ret_i(1'b0), .pc_o(b_pc), .epc_o(b_epc), .ras_empty_o(b_empty),
    .ras_full_o(b_full), .ras_ovf_o(b_ovf), .ret_err_o(b_rerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_err, m_valid;

  function automatic void m_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > 4) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_step();
    logic [31:0] seq;
    logic [31:0] t;
    seq = m_pc + 32'd4;
    if (!rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_ovf = 1'b0; m_err = 1'b0;
      m_valid = 1'b1;
    end else if (!start) begin
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (exc) begin
        m_epc = m_pc; m_pc = 32'h80;
      end else if (br) begin
        m_pc = br_tgt;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (call && ret) begin
        if (m_ras.size() > 0) begin
          t = m_ras[m_ras.size()-1];
          m_ras[m_ras.size()-1] = seq;
          m_pc = t;
        end else begin
          m_push(seq); m_pc = jmp_tgt; m_err = 1'b1;
        end
      end else if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = seq; m_err = 1'b1; end
      end else if (call) begin
        m_push(seq); m_pc = jmp_tgt;
      end else begin
        m_pc = seq;
      end
    end
  endfunction

  // Compare process: model advances with each edge, DUT checked 1 time unit later
  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      model_step();
      if (m_valid) begin
        chk("pc",    pc,    m_pc);
        chk("epc",   epc,   m_epc);
        chk("empty", {31'd0, empty}, {31'd0, m_ras.size() == 0});
        chk("full",  {31'd0, full},  {31'd0, m_ras.size() == 4});
        chk("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
        chk("rerr",  {31'd0, rerr},  {31'd0, m_err});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    rst = 1'b1; start = 1'b1; stall = 1'b0; exc = 1'b0; br = 1'b0;
    call = 1'b0; ret = 1'b0; br_tgt = 32'h0; jmp_tgt = 32'h0;
    b_br = 1'b0; b_tgt = 8'h00;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle(); call = 1'b1; jmp_tgt = tgt; cyc(1);
  endtask

  task automatic do_ret();
    idle(); ret = 1'b1; cyc(1);
  endtask

  task automatic do_br(input logic [31:0] tgt);
    idle(); br = 1'b1; br_tgt = tgt; cyc(1);
  endtask

  initial begin
    idle(); rst = 1'b0; start = 1'b0;
    cyc(2);
    chk("pin_rst_pc", pc, 32'h0);
    chk("pin_rst_empty", {31'd0, empty}, 32'd1);
    chk("pin_rst_full", {31'd0, full}, 32'd0);

    // run: 0 -> 4 -> 8 -> 12
    idle(); cyc(1); chk("pin_run1", pc, 32'h4);
    cyc(1);         chk("pin_run2", pc, 32'h8);
    cyc(1);         chk("pin_run3", pc, 32'hC);
    // freeze
    start = 1'b0; cyc(3); chk("pin_freeze", pc, 32'hC);

    // stall at 8
    do_br(32'h8);
    idle(); stall = 1'b1; cyc(3); chk("pin_stall", pc, 32'h8);
    br = 1'b1; br_tgt = 32'h40; cyc(1); chk("pin_stall_br", pc, 32'h40);
    idle(); cyc(1); chk("pin_after_stall", pc, 32'h44);

    // exception beats branch and call
    do_br(32'h1C);
    idle(); exc = 1'b1; br = 1'b1; br_tgt = 32'h500; call = 1'b1; jmp_tgt = 32'h600;
    cyc(1);
    chk("pin_exc_pc", pc, 32'h80);
    chk("pin_exc_epc", epc, 32'h1C);
    chk("pin_exc_empty", {31'd0, empty}, 32'd1);

    // overflow: five calls from 0x00..0x40
    do_br(32'h0);
    for (int i = 0; i < 5; i++) begin
      do_call(32'(i) * 32'h10 + 32'h10);
      if (i == 3) begin
        chk("pin_full4", {31'd0, full}, 32'd1);
        chk("pin_noovf4", {31'd0, ovf}, 32'd0);
      end
    end
    chk("pin_ovf5", {31'd0, ovf}, 32'd1);
    do_ret(); chk("pin_ret1", pc, 32'h44);
    do_ret(); chk("pin_ret2", pc, 32'h34);
    do_ret(); chk("pin_ret3", pc, 32'h24);
    do_ret(); chk("pin_ret4", pc, 32'h14);
    do_ret();
    chk("pin_ret5_pc", pc, 32'h18);
    chk("pin_ret5_err", {31'd0, rerr}, 32'd1);
    chk("pin_ret5_empty", {31'd0, empty}, 32'd1);
    idle(); cyc(1); chk("pin_err_drop", {31'd0, rerr}, 32'd0);

    // swap: top=0x100, pc=0x200
    do_br(32'hFC);
    do_call(32'h200);
    idle(); call = 1'b1; ret = 1'b1; jmp_tgt = 32'h999; cyc(1);
    chk("pin_swap_pc", pc, 32'h100);
    do_ret(); chk("pin_swap_top", pc, 32'h204);
    // swap with empty RAS acts as a call and flags the return
    idle(); call = 1'b1; ret = 1'b1; jmp_tgt = 32'h300; cyc(1);
    chk("pin_eswap_pc", pc, 32'h300);
    chk("pin_eswap_err", {31'd0, rerr}, 32'd1);
    do_ret(); chk("pin_eswap_ret", pc, 32'h208);

    // reset during stall + redirect with a full, overflowed RAS
    for (int i = 0; i < 5; i++) do_call(32'h1000);
    idle(); rst = 1'b0; stall = 1'b1; br = 1'b1; br_tgt = 32'h40; call = 1'b1; cyc(1);
    chk("pin_midrst_pc", pc, 32'h0);
    chk("pin_midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("pin_midrst_empty", {31'd0, empty}, 32'd1);

    // 32-bit wrap
    idle(); cyc(1);
    do_br(32'hFFFF_FFFC);
    idle(); cyc(1); chk("pin_wrap32", pc, 32'h0);

    // 8-bit wrap
    idle(); b_br = 1'b1; b_tgt = 8'hFC; cyc(1);
    chk("pin_b_tgt", {24'd0, b_pc}, 32'hFC);
    idle(); cyc(1);
    chk("pin_wrap8", {24'd0, b_pc}, 32'h00);

    cyc(1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
